cla_subtractor: RTL and testbench
=================================

Name: cla_subtractor

Overview:
- Multi-cycle, nibble-serial two's-complement subtractor for the 8-bit datapath: computes D = A - B - b_in.
- Companion to the 4-bit carry-lookahead adder; uses the same level-sensitive en/ready handshake, so the ALU sequencer drives both identically.
- Uses one 4-bit borrow-lookahead slice per cycle, least-significant nibble first, and registers the result and flags.

Parameters:
- NIBBLES, 2, number of 4-bit slices; operand width W = 4*NIBBLES (8 by default).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  request level; held high for the whole operation; low aborts/clears.
- A  input  W  minuend; sampled only at operation start.
- B  input  W  subtrahend; sampled only at operation start.
- b_in  input  1  borrow in; sampled only at operation start.
- Output  output  W  registered difference.
- b_out  output  1  registered borrow out (1 when A < B + b_in, unsigned).
- zero  output  1  registered, Output == 0.
- negative  output  1  registered, Output[W-1].
- overflow  output  1  registered signed overflow: (A[W-1] != B[W-1]) && (Output[W-1] != A[W-1]).
- ready  output  1  result valid; high only in DONE.

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE, nibble index 0, Output 0, b_out 0, zero 0, negative 0, overflow 0, ready 0, operand latches 0.
- States and transitions:
  - IDLE: en=1 at an edge latches A, B and b_in into internal registers, clears the nibble index, then goes to RUN.
  - RUN: each edge computes slice i = latchA[i] - latchB[i] - borrow with the lookahead slice. The 4-bit result is written into the Output shadow register at nibble i, and the slice borrow is registered. After the last slice (i = NIBBLES-1), the state goes to DONE, and Output, b_out and flags update together, ready <= 1.
  - DONE: ready stays 1 while en=1. en=0 at an edge returns to IDLE with ready <= 0.
- Latency: with en sampled high at edge k in IDLE, ready is first high after edge k+NIBBLES (k+2 by default).
- Output and flags are visible only from DONE onward. They hold their last values through IDLE until the next operation completes; no partial results are ever visible on Output.
- Operand changes after the start edge are ignored.
- Abort: en=0 at any edge during RUN returns to IDLE, discards the partial result and leaves the previous Output/flags unchanged. ready stays 0.
- Re-start: a new operation needs en to drop through IDLE. If en is held high in DONE, no recomputation occurs.
- Arithmetic: modulo 2^W. Each slice uses generate g = ~a & b and propagate p = ~(a ^ b). Borrow chain: c[j+1] = g[j] | (p[j] & c[j]); d[j] = a[j] ^ b[j] ^ c[j].
- Reset asserted mid-RUN or in DONE takes immediate effect (asynchronous). After reset deasserts, the next en=1 edge starts a fresh operation.

Decomposition:
- Shared package cla_pkg holds:
  - constant NIBBLE_W = 4;
  - state enum {IDLE, RUN, DONE};
  - the shared handshake description, also adopted by the adder.
- One sub-module: bla_slice4 (combinational 4-bit borrow-lookahead slice). Inputs a[3:0], b[3:0], bin; outputs d[3:0], bout. It is instantiated once and reused every cycle via operand muxing on the nibble index.

Test Plan:
- A=8'h35, B=8'h12, b_in=0, en held -> ready after 2 edges; Output=8'h23, b_out=0, zero=0, negative=0, overflow=0.
- A=8'h00, B=8'h01, b_in=0 -> Output=8'hFF, b_out=1, negative=1, overflow=0, zero=0.
- A=8'h80, B=8'h01 -> Output=8'h7F, overflow=1, b_out=0; then A=8'h10, B=8'h0F, b_in=1 -> Output=8'h00, zero=1, b_out=0.
- Start A=8'h47, B=8'h47 completes (zero=1). Then start A=8'h50, B=8'h20 and drop en after 1 edge -> ready never rises; Output stays 8'h00, zero stays 1; restart with en completes with 8'h30.
- Change A/B every cycle during RUN -> Output reflects only the operands sampled at the start edge.
- Assert reset mid-RUN (asynchronous, between edges) -> all outputs 0 immediately, ready 0; next en=1 produces the correct result with standard latency.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor pair: slice width,
// sequencer states and the en/ready handshake both blocks present to the ALU.
package cla_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   // en is a level held for the whole operation; dropping it aborts or retires.
   // ready is high only in DONE and falls on the first edge that sees en low.
   typedef struct packed {
      logic en;
      logic ready;
   } handshake_t;

   // Index register width; stays at least one bit for a single-slice build.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/bla_slice4.sv
// Combinational 4-bit borrow-lookahead slice: d = a - b - bin, bout is the
// borrow leaving bit 3.
module bla_slice4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   // A bit borrows on its own when a=0,b=1 and passes a borrow through when a==b.
   assign g = ~a & b;
   assign p = ~(a ^ b);

   assign c[0] = bin;
   assign c[1] = g[0] | (p[0] & bin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin);

   assign d    = a ^ b ^ c[3:0];
   assign bout = c[4];

endmodule

// File: rtl/cla_subtractor.sv
// Nibble-serial subtractor: one borrow-lookahead slice reused LSB nibble first;
// result and flags are published together when the last slice completes.
module cla_subtractor
   import cla_pkg::*;
#(
   parameter  int NIBBLES = 2,
   localparam int W       = NIBBLE_W * NIBBLES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         b_in,
   output logic [W-1:0] Output,
   output logic         b_out,
   output logic         zero,
   output logic         negative,
   output logic         overflow,
   output logic         ready
);

   localparam int              IDX_W    = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [W-1:0]         a_q, a_d;
   logic [W-1:0]         b_q, b_d;
   logic                 brw_q, brw_d;
   logic [W-1:0]         shadow_q, shadow_d;
   logic [W-1:0]         out_q, out_d;
   logic                 bout_q, bout_d;
   logic                 zero_q, zero_d;
   logic                 neg_q, neg_d;
   logic                 ovf_q, ovf_d;
   logic                 ready_q, ready_d;

   logic [NIBBLE_W-1:0]  a_nib, b_nib, d_nib;
   logic                 bout_nib;
   logic [W-1:0]         merged;

   // Operand mux: pick the current nibble of the latched operands.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
            b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   bla_slice4 u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .bin  (brw_q),
      .d    (d_nib),
      .bout (bout_nib)
   );

   always_comb begin
      merged = shadow_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            merged[i*NIBBLE_W +: NIBBLE_W] = d_nib;
         end
      end
   end

   always_comb begin
      // NOTE: every next-state value defaults to its current value first, so no
      // path through the case statement can leave a variable unassigned (latch).
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      brw_d    = brw_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      bout_d   = bout_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      ready_d  = ready_q;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               a_d     = A;
               b_d     = B;
               brw_d   = b_in;
               idx_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            if (!en) begin
               // Abort: partial shadow is simply never published.
               state_d = IDLE;
            end else begin
               shadow_d = merged;
               brw_d    = bout_nib;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  out_d   = merged;
                  bout_d  = bout_nib;
                  zero_d  = (merged == '0);
                  neg_d   = merged[W-1];
                  ovf_d   = (a_q[W-1] != b_q[W-1]) && (merged[W-1] != a_q[W-1]);
                  ready_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         DONE: begin
            if (!en) begin
               state_d = IDLE;
               ready_d = 1'b0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: the operand latches and shadow are datapath-only, but they are reset
   // too so a restart after reset never sees stale values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         brw_q    <= 1'b0;
         shadow_q <= '0;
         out_q    <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         brw_q    <= brw_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         bout_q   <= bout_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         ready_q  <= ready_d;
      end
   end

   assign Output   = out_q;
   assign b_out    = bout_q;
   assign zero     = zero_q;
   assign negative = neg_q;
   assign overflow = ovf_q;
   assign ready    = ready_q;

endmodule

// File: tb/tb_cla_subtractor.sv
// Directed bench for cla_subtractor: hand-computed differences, flags, latency,
// hold, abort, operand-change immunity and asynchronous reset.
module tb_cla_subtractor;

   logic       clk;
   logic       reset;
   logic       en;
   logic [7:0] A;
   logic [7:0] B;
   logic       b_in;
   logic [7:0] Output;
   logic       b_out;
   logic       zero;
   logic       negative;
   logic       overflow;
   logic       ready;

   int total = 0;
   int bad   = 0;

   cla_subtractor #(.NIBBLES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .A        (A),
      .B        (B),
      .b_in     (b_in),
      .Output   (Output),
      .b_out    (b_out),
      .zero     (zero),
      .negative (negative),
      .overflow (overflow),
      .ready    (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic [7:0] eo, input logic eb,
                               input logic ez, input logic eneg, input logic eov);
      check({tag, ".out"},  {24'h0, Output}, {24'h0, eo});
      check({tag, ".bout"}, {31'h0, b_out},    {31'h0, eb});
      check({tag, ".zero"}, {31'h0, zero},     {31'h0, ez});
      check({tag, ".neg"},  {31'h0, negative}, {31'h0, eneg});
      check({tag, ".ovf"},  {31'h0, overflow}, {31'h0, eov});
   endtask

   // Start from IDLE, hold en, expect ready exactly two edges after the start edge.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] eo, input logic eb,
                        input logic ez, input logic eneg, input logic eov);
      A = a; B = b; b_in = bi; en = 1'b1;
      step();
      check({tag, ".rdy_e1"}, {31'h0, ready}, 32'h0);
      step();
      check({tag, ".rdy_e2"}, {31'h0, ready}, 32'h0);
      step();
      check({tag, ".rdy_done"}, {31'h0, ready}, 32'h1);
      check_result(tag, eo, eb, ez, eneg, eov);
   endtask

   task automatic release_en(input string tag);
      en = 1'b0;
      step();
      check({tag, ".rdy_low"}, {31'h0, ready}, 32'h0);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; A = '0; B = '0; b_in = 1'b0;
      #2;
      check({"rst", ".rdy"}, {31'h0, ready}, 32'h0);
      check_result("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b0;
      step();

      // Basic difference, then hold en in DONE while operands change: no recompute.
      do_op("t35m12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
      A = 8'hAA; B = 8'h01;
      step();
      step();
      check("hold.rdy", {31'h0, ready}, 32'h1);
      check_result("hold", 8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
      release_en("t35m12");
      check_result("idle_keep", 8'h23, 1'b0, 1'b0, 1'b0, 1'b0);

      do_op("t00m01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
      release_en("t00m01");

      do_op("t80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
      release_en("t80m01");

      do_op("t10m0F_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      release_en("t10m0F_b");

      // Abort during RUN keeps previous result and never raises ready.
      do_op("t47m47", 8'h47, 8'h47, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      release_en("t47m47");
      A = 8'h50; B = 8'h20; b_in = 1'b0; en = 1'b1;
      step();
      en = 1'b0;
      step();
      check("abort.rdy1", {31'h0, ready}, 32'h0);
      step();
      check("abort.rdy2", {31'h0, ready}, 32'h0);
      check_result("abort", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      do_op("t50m20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      release_en("t50m20");

      // Operands and borrow-in scrambled every cycle after the start edge.
      A = 8'h9C; B = 8'h3A; b_in = 1'b0; en = 1'b1;
      step();
      A = 8'hFF; B = 8'h00; b_in = 1'b1;
      step();
      A = 8'h01; B = 8'hF0; b_in = 1'b1;
      step();
      check("scramble.rdy", {31'h0, ready}, 32'h1);
      check_result("scramble", 8'h62, 1'b0, 1'b0, 1'b0, 1'b1);
      release_en("scramble");

      // Asynchronous reset between edges during RUN.
      A = 8'hC3; B = 8'h05; b_in = 1'b0; en = 1'b1;
      step();
      #3 reset = 1'b1;
      #1;
      check("arst.rdy", {31'h0, ready}, 32'h0);
      check_result("arst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b0;
      do_op("tC3m05", 8'hC3, 8'h05, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);
      release_en("tC3m05");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
